// File: rtl/bcd_descontador_if.sv
// Control and status bundle for the BCD down-counter: the master drives the
// load/enable controls, and the slave (the counter) returns the count and its flags.
interface bcd_descontador_if #(
    parameter int DIGITS = 2
);
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  cnt;
    logic [4*DIGITS-1:0]   Q;
    logic                  zero;
    logic                  done;

    modport master (output load, load_val, cnt, input Q, zero, done);
    modport slave  (input load, load_val, cnt, output Q, zero, done);
endinterface

// File: rtl/bcd_descontador.sv
// Multi-digit BCD down-counter with parallel load (digit clamping), zero flag
// and a one-cycle terminal-count pulse. WRAP selects saturation or wrap to all-nines.
module bcd_descontador #(
    parameter int DIGITS = 2,
    parameter bit WRAP   = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    bcd_descontador_if.slave bus
);
    localparam int W = 4*DIGITS;

    logic [W-1:0]    q_r;
    logic            zero_r;
    logic            done_r;
    logic [W-1:0]    dec_val;
    logic [W-1:0]    ld_val;
    logic [W-1:0]    nines;
    logic [DIGITS:0] borrow;

    assign borrow[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        logic [3:0] d;
        logic [3:0] lv;
        assign d  = q_r[4*g +: 4];
        assign lv = bus.load_val[4*g +: 4];
        // A digit only changes when the borrow reaches it; a zero digit passes it on.
        assign dec_val[4*g +: 4] = borrow[g] ? ((d == 4'd0) ? 4'd9 : d - 4'd1) : d;
        assign borrow[g+1]       = borrow[g] & (d == 4'd0);
        assign ld_val[4*g +: 4]  = (lv > 4'd9) ? 4'd9 : lv;
        assign nines[4*g +: 4]   = 4'd9;
    end

    // Borrow out of the top digit means the count is already zero.
    always_ff @(posedge clk) begin
        if (!clr) begin
            q_r    <= '0;
            zero_r <= 1'b1;
            done_r <= 1'b0;
        end else if (bus.load) begin
            q_r    <= ld_val;
            zero_r <= (ld_val == '0);
            done_r <= 1'b0;
        end else if (bus.cnt) begin
            if (borrow[DIGITS]) begin
                if (WRAP) begin
                    q_r    <= nines;
                    zero_r <= 1'b0;
                end
                done_r <= 1'b0;
            end else begin
                q_r    <= dec_val;
                zero_r <= (dec_val == '0);
                done_r <= (dec_val == '0);
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign bus.Q    = q_r;
    assign bus.zero = zero_r;
    assign bus.done = done_r;
endmodule

// File: tb/tb_bcd_descontador.sv
// Directed bench for bcd_descontador: a vector table on a 2-digit saturating
// counter, plus hand sequences for wrap, 3-digit borrow and reset glitches.
module tb_bcd_descontador;
    logic clk;
    logic clr;
    int   n_chk;
    int   n_fail;

    bcd_descontador_if #(.DIGITS(2)) b0 ();
    bcd_descontador_if #(.DIGITS(2)) b1 ();
    bcd_descontador_if #(.DIGITS(3)) b2 ();

    bcd_descontador #(.DIGITS(2), .WRAP(1'b0)) u0 (.clk(clk), .clr(clr), .bus(b0));
    bcd_descontador #(.DIGITS(2), .WRAP(1'b1)) u1 (.clk(clk), .clr(clr), .bus(b1));
    bcd_descontador #(.DIGITS(3), .WRAP(1'b0)) u2 (.clk(clk), .clr(clr), .bus(b2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       load;
        logic [7:0] lv;
        logic       cnt;
        logic [7:0] q;
        logic       z;
        logic       d;
    } vec_t;

    vec_t tbl[64];
    int   n_vec;

    task automatic add(input logic c, input logic l, input logic [7:0] lv,
                       input logic e, input logic [7:0] q, input logic z, input logic d);
        tbl[n_vec] = '{c, l, lv, e, q, z, d};
        n_vec++;
    endtask

    task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle_all();
        b0.load = 1'b0; b0.load_val = '0; b0.cnt = 1'b0;
        b1.load = 1'b0; b1.load_val = '0; b1.cnt = 1'b0;
        b2.load = 1'b0; b2.load_val = '0; b2.cnt = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        n_vec = 0;
        clr = 1'b1;
        idle_all();

        add(0, 0, 8'h00, 1, 8'h00, 1, 0);
        add(1, 0, 8'h00, 1, 8'h00, 1, 0);
        add(1, 0, 8'h00, 1, 8'h00, 1, 0);
        add(1, 1, 8'h12, 0, 8'h12, 0, 0);
        add(1, 0, 8'h00, 1, 8'h11, 0, 0);
        add(1, 0, 8'h00, 1, 8'h10, 0, 0);
        add(1, 0, 8'h00, 1, 8'h09, 0, 0);
        add(1, 0, 8'h00, 1, 8'h08, 0, 0);
        add(1, 0, 8'h00, 1, 8'h07, 0, 0);
        add(1, 0, 8'h00, 1, 8'h06, 0, 0);
        add(1, 0, 8'h00, 1, 8'h05, 0, 0);
        add(1, 0, 8'h00, 1, 8'h04, 0, 0);
        add(1, 0, 8'h00, 1, 8'h03, 0, 0);
        add(1, 0, 8'h00, 1, 8'h02, 0, 0);
        add(1, 0, 8'h00, 1, 8'h01, 0, 0);
        add(1, 0, 8'h00, 1, 8'h00, 1, 1);
        add(1, 0, 8'h00, 1, 8'h00, 1, 0);
        add(1, 0, 8'h00, 0, 8'h00, 1, 0);
        add(1, 1, 8'h3F, 0, 8'h39, 0, 0);
        add(1, 1, 8'hA3, 0, 8'h93, 0, 0);
        add(1, 1, 8'hAF, 1, 8'h99, 0, 0);
        add(1, 1, 8'h25, 1, 8'h25, 0, 0);
        add(1, 1, 8'h50, 0, 8'h50, 0, 0);
        add(1, 0, 8'h00, 1, 8'h49, 0, 0);
        add(1, 0, 8'h00, 0, 8'h49, 0, 0);
        add(1, 0, 8'h00, 1, 8'h48, 0, 0);
        add(1, 0, 8'h00, 0, 8'h48, 0, 0);
        add(1, 1, 8'h07, 0, 8'h07, 0, 0);
        add(0, 1, 8'h33, 1, 8'h00, 1, 0);
        add(1, 1, 8'h00, 0, 8'h00, 1, 0);
        add(1, 1, 8'h01, 0, 8'h01, 0, 0);
        add(1, 1, 8'h01, 1, 8'h01, 0, 0);
        add(1, 0, 8'h00, 1, 8'h00, 1, 1);
        add(1, 0, 8'h00, 0, 8'h00, 1, 0);

        for (int i = 0; i < n_vec; i++) begin
            @(negedge clk);
            clr         = tbl[i].clr;
            b0.load     = tbl[i].load;
            b0.load_val = tbl[i].lv;
            b0.cnt      = tbl[i].cnt;
            tick();
            chk($sformatf("vec%0d.Q", i),    {4'h0, b0.Q}, {4'h0, tbl[i].q});
            chk($sformatf("vec%0d.zero", i), {11'h0, b0.zero}, {11'h0, tbl[i].z});
            chk($sformatf("vec%0d.done", i), {11'h0, b0.done}, {11'h0, tbl[i].d});
        end

        // Reset glitch between edges must be ignored.
        @(negedge clk);
        clr = 1'b1; idle_all();
        b0.load = 1'b1; b0.load_val = 8'h07;
        tick();
        @(negedge clk);
        b0.load = 1'b0; b0.cnt = 1'b0;
        #1 clr = 1'b0;
        #2 clr = 1'b1;
        tick();
        chk("glitch.Q", {4'h0, b0.Q}, 12'h007);
        chk("glitch.zero", {11'h0, b0.zero}, 12'h000);

        // Wrap instance: reset, underflow to 99, continue to 98, terminal pulse.
        @(negedge clk);
        idle_all(); clr = 1'b0;
        tick();
        chk("wrap.rst.Q", {4'h0, b1.Q}, 12'h000);
        @(negedge clk);
        clr = 1'b1; b1.cnt = 1'b1;
        tick();
        chk("wrap.99.Q", {4'h0, b1.Q}, 12'h099);
        chk("wrap.99.zero", {11'h0, b1.zero}, 12'h000);
        chk("wrap.99.done", {11'h0, b1.done}, 12'h000);
        tick();
        chk("wrap.98.Q", {4'h0, b1.Q}, 12'h098);
        @(negedge clk);
        b1.load = 1'b1; b1.load_val = 8'h01; b1.cnt = 1'b0;
        tick();
        @(negedge clk);
        b1.load = 1'b0; b1.cnt = 1'b1;
        tick();
        chk("wrap.0.done", {11'h0, b1.done}, 12'h001);
        chk("wrap.0.zero", {11'h0, b1.zero}, 12'h001);
        tick();
        chk("wrap.again.Q", {4'h0, b1.Q}, 12'h099);
        chk("wrap.again.done", {11'h0, b1.done}, 12'h000);

        // Three digits: 100 -> 099 -> 098.
        @(negedge clk);
        idle_all();
        b2.load = 1'b1; b2.load_val = 12'h100;
        tick();
        chk("d3.load.Q", b2.Q, 12'h100);
        @(negedge clk);
        b2.load = 1'b0; b2.cnt = 1'b1;
        tick();
        chk("d3.099.Q", b2.Q, 12'h099);
        tick();
        chk("d3.098.Q", b2.Q, 12'h098);
        chk("d3.098.zero", {11'h0, b2.zero}, 12'h000);
        @(negedge clk);
        b2.cnt = 1'b0; b2.load = 1'b1; b2.load_val = 12'hF0A;
        tick();
        chk("d3.clamp.Q", b2.Q, 12'h909);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
